// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and types for the ExpandA rejection sampler.
package dilithium_pkg;

    localparam logic [22:0] Q = 23'd8380417;
    localparam int          N = 256;

    typedef logic [22:0] coeff_t;
    typedef logic [7:0]  idx_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/rej_ntt_poly_sampler_if.sv
// XOF word stream in, indexed coefficient stream out; the sampler is the slave side.
interface rej_ntt_poly_sampler_if;
    import dilithium_pkg::*;

    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    coeff_t      coeff_out;
    idx_t        coeff_idx;
    logic        coeff_valid;
    logic        coeff_ready;

    modport slave (
        input  in_data, in_valid, coeff_ready,
        output in_ready, coeff_out, coeff_idx, coeff_valid
    );

    modport master (
        output in_data, in_valid, coeff_ready,
        input  in_ready, coeff_out, coeff_idx, coeff_valid
    );

endinterface

// File: rtl/rej_byte_buffer.sv
// 10-byte shift buffer: appends an 8-byte word behind the held bytes, drops 3 from the head.
module rej_byte_buffer #(
    parameter int WORD_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              drop,
    input  logic              clear,
    output logic [23:0]       head,
    output logic [3:0]        cnt
);

    logic [79:0] sbuf_q, sbuf_d;
    logic [3:0]  cnt_q, cnt_d;

    // Loads only happen with fewer than 3 bytes held, so only 3 placements exist.
    always_comb begin
        sbuf_d = sbuf_q;
        cnt_d  = cnt_q;
        if (clear) begin
            sbuf_d = '0;
            cnt_d  = 4'd0;
        end else if (load) begin
            case (cnt_q)
                4'd0:    sbuf_d = {16'h0, word};
                4'd1:    sbuf_d = {8'h0, word, sbuf_q[7:0]};
                default: sbuf_d = {word, sbuf_q[15:0]};
            endcase
            cnt_d = cnt_q + 4'd8;
        end else if (drop) begin
            sbuf_d = {24'h0, sbuf_q[79:24]};
            cnt_d  = cnt_q - 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sbuf_q <= '0;
            cnt_q  <= 4'd0;
        end else begin
            sbuf_q <= sbuf_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head = sbuf_q[23:0];
    assign cnt  = cnt_q;

endmodule

// File: rtl/rej_ntt_poly_sampler.sv
// RejNTTPoly sampler: 3-byte groups masked to 23 bits, kept if < Q, emitted with index.
// Optional REJ_SAMPLER_STATS_EN adds a saturating rejected-candidate counter port rej_count.
module rej_ntt_poly_sampler #(
    parameter int          N      = dilithium_pkg::N,
    parameter logic [22:0] Q      = dilithium_pkg::Q,
    parameter int          WORD_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    rej_ntt_poly_sampler_if.slave  bus,
    output logic                   busy,
    output logic                   done
`ifdef REJ_SAMPLER_STATS_EN
    ,
    output logic [15:0]            rej_count
`endif
);
    import dilithium_pkg::coeff_t;
    import dilithium_pkg::idx_t;
    import dilithium_pkg::state_e;
    import dilithium_pkg::IDLE;
    import dilithium_pkg::RUN;
    import dilithium_pkg::DRAIN;

    state_e     state_q, state_d;
    logic [8:0] acc_q, acc_d;
    coeff_t     coeff_out_q, coeff_out_d;
    idx_t       coeff_idx_q, coeff_idx_d;
    logic       coeff_valid_q, coeff_valid_d;
    logic       done_q, done_d;
`ifdef REJ_SAMPLER_STATS_EN
    logic [15:0] rej_q, rej_d;
`endif

    logic [23:0] head;
    logic [3:0]  byte_cnt;
    logic        buf_load, buf_drop, buf_clear;
    coeff_t      cand;
    logic        cand_vld, cand_acc, out_free, out_hs;
    logic        unused_head_msb;

    rej_byte_buffer #(.WORD_W(WORD_W)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (buf_load),
        .word  (bus.in_data),
        .drop  (buf_drop),
        .clear (buf_clear),
        .head  (head),
        .cnt   (byte_cnt)
    );

    // Bit 23 of each group is discarded, leaving a 23-bit candidate.
    assign cand            = head[22:0];
    assign unused_head_msb = head[23];
    assign cand_vld        = (state_q == RUN) && (byte_cnt >= 4'd3);
    assign cand_acc        = (cand < Q);
    assign out_hs          = coeff_valid_q && bus.coeff_ready;
    assign out_free        = !coeff_valid_q || bus.coeff_ready;

    assign bus.in_ready = (state_q == RUN) && (byte_cnt < 4'd3);
    assign buf_load     = bus.in_ready && bus.in_valid && !start;

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        coeff_out_d   = coeff_out_q;
        coeff_idx_d   = coeff_idx_q;
        coeff_valid_d = coeff_valid_q;
        done_d        = 1'b0;
        buf_drop      = 1'b0;
        buf_clear     = 1'b0;
`ifdef REJ_SAMPLER_STATS_EN
        rej_d         = rej_q;
`endif
        if (start) begin
            state_d       = RUN;
            acc_d         = '0;
            coeff_valid_d = 1'b0;
            buf_clear     = 1'b1;
`ifdef REJ_SAMPLER_STATS_EN
            rej_d         = '0;
`endif
        end else begin
            if (out_hs) coeff_valid_d = 1'b0;
            case (state_q)
                RUN: begin
                    if (cand_vld) begin
                        if (!cand_acc) begin
                            buf_drop = 1'b1;
`ifdef REJ_SAMPLER_STATS_EN
                            if (rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
`endif
                        end else if (out_free) begin
                            coeff_out_d   = cand;
                            coeff_idx_d   = acc_q[7:0];
                            coeff_valid_d = 1'b1;
                            acc_d         = acc_q + 9'd1;
                            buf_drop      = 1'b1;
                            // Last coefficient: flush leftover bytes so no further words are taken.
                            if (acc_q == 9'(N - 1)) begin
                                state_d   = DRAIN;
                                buf_clear = 1'b1;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            acc_q         <= '0;
            coeff_out_q   <= '0;
            coeff_idx_q   <= '0;
            coeff_valid_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef REJ_SAMPLER_STATS_EN
            rej_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            coeff_out_q   <= coeff_out_d;
            coeff_idx_q   <= coeff_idx_d;
            coeff_valid_q <= coeff_valid_d;
            done_q        <= done_d;
`ifdef REJ_SAMPLER_STATS_EN
            rej_q         <= rej_d;
`endif
        end
    end

    assign bus.coeff_out   = coeff_out_q;
    assign bus.coeff_idx   = coeff_idx_q;
    assign bus.coeff_valid = coeff_valid_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
`ifdef REJ_SAMPLER_STATS_EN
    assign rej_count       = rej_q;
`endif

endmodule

// File: doc/rej_ntt_poly_sampler.md
# rej_ntt_poly_sampler

Rejection sampler for ExpandA (RejNTTPoly). It sits between the SHAKE128 squeeze output and the matrix-A polynomial RAM. It consumes the XOF byte stream as 64-bit words and slices it into 3-byte groups. Each group is masked to 23 bits and kept only if below q; accepted values are emitted as 256 NTT-domain coefficients, each tagged with its index.

## Interface
- `N` — default 256 — coefficients per polynomial.
- `Q` — default 8380417 — modulus; a candidate is accepted iff it is < Q.
- `WORD_W` — default 64 — XOF word width. Fixed at 64; other values are unsupported.
- `clk` — in, 1 — single clock, rising edge.
- `rst_n` — in, 1 — asynchronous, active-low reset.
- `start` — in, 1 — one-cycle pulse; (re)initialises the sampler in any state.
- `in_data` — in, 64 — XOF word; stream byte k is `in_data[8k+7:8k]`.
- `in_valid` — in, 1 — `in_data` is valid.
- `in_ready` — out, 1 — sampler accepts a word this cycle.
- `coeff_out` — out, 23 — accepted coefficient, range 0..Q-1.
- `coeff_idx` — out, 8 — index of `coeff_out`, 0..N-1.
- `coeff_valid` — out, 1 — output register holds a coefficient.
- `coeff_ready` — in, 1 — consumer takes the coefficient.
- `busy` — out, 1 — high in RUN and DRAIN.
- `done` — out, 1 — one-cycle pulse after coefficient N-1 is handshaken.

## Operation
**States:** IDLE, RUN, DRAIN.
- IDLE → RUN on `start`.
- RUN → DRAIN when the N-th accepted coefficient is loaded into the output register.
- DRAIN → IDLE on its handshake; `done` pulses in the cycle after.
- `start` in any state:
  - clears the byte buffer, the accept counter and `coeff_valid`;
  - state goes to RUN;
  - any in-flight coefficient is discarded without a handshake.

**Byte buffer:**
- 10-byte shift buffer with a `byte_cnt` register (0..10).
- `in_ready` = RUN && `byte_cnt` < 3.
- On a word handshake, the 8 bytes are appended after the existing bytes, in stream order.

**Candidate formation:**
- When RUN && `byte_cnt` ≥ 3, the oldest three bytes b0, b1, b2 form cand = {b2 & 8'h7F, b1, b0}.
- Bit 23 of the group is cleared, giving a 23-bit cand.

**Accept/reject:**
- Reject (cand ≥ Q): drop 3 bytes, regardless of output state.
- Accept (cand < Q): requires the output register to be free, i.e. `!coeff_valid` || `coeff_ready`.
  - If free: load `coeff_out` = cand and `coeff_idx` = accept counter, set `coeff_valid`, increment the counter, drop 3 bytes.
  - If not free: stall, with the buffer unchanged.

**Completion:**
- When the counter reaches N, the remaining buffered bytes are discarded and `byte_cnt` is set to 0.
- `in_ready` stays 0 until the next `start`.

**Other rules:**
- Load and extract never coincide, because a load only occurs when `byte_cnt` < 3.
- Arithmetic: the accept counter is 9 bits (0..256); `coeff_idx` is its low 8 bits, captured at load.

## Timing
**Reset values:**
- `in_ready`=0, `coeff_valid`=0, `coeff_out`=0, `coeff_idx`=0, `busy`=0, `done`=0.
- State IDLE, `byte_cnt`=0.

**Latency and throughput:**
- Word handshake at edge t with `byte_cnt`=0: the first candidate is evaluated in cycle t+1, and `coeff_valid` is high from edge t+1 if accepted.
- Each cycle after that evaluates at most one candidate.
- Sustained rate: 8 candidates per 3 words.

**Handshakes:**
- `coeff_valid`/`coeff_out`/`coeff_idx` are registered and hold stable until `coeff_valid` && `coeff_ready`.
- Back-to-back handshakes are allowed.
- `in_ready` is registered-state derived only; it has no combinational path from `in_valid` or `coeff_ready`.

**Boundary cases:**
- An `in_valid` held while `in_ready`=0 is not consumed.
- A `start` coincident with a handshake: `start` wins and the handshake is ignored.
- `done` is high for exactly one cycle per completed polynomial.
- Reset mid-operation returns all state to reset values immediately.

## Configuration
Macro `REJ_SAMPLER_STATS_EN`:
- **Defined:** adds the output port `rej_count` (16 bits).
  - Counts rejected candidates since the last `start`, saturating at 16'hFFFF.
  - Cleared by `start` and by reset.
- **Undefined:** the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `dilithium_pkg` holds:
  - `Q`=23'd8380417, `N`=256, the 23-bit coefficient typedef, the 8-bit index typedef.
  - The sampler state enum {IDLE, RUN, DRAIN}.
- Sub-module `rej_byte_buffer` holds the 10-byte shift buffer with `byte_cnt`.
  - Ports: load word, drop-3, clear, head 24 bits, count.
- The top level keeps the FSM, the candidate compare, the accept counter and the output register.

## Test plan
1. **Basic accept.** `start`, then word bytes 01 00 00 | 00 E0 FF | 01 E0 … → coeff idx0 = 1, then idx1 = 8380416 (0xFF masked to 0x7F gives 0x7FE000 = Q-1).
2. **Reject at q.** Group 01 E0 7F (0x7FE001 = Q), then FF FF FF (0x7FFFFF) → both rejected, no `coeff_valid`; `rej_count`=2 when `REJ_SAMPLER_STATS_EN` is defined.
3. **Word-straddling groups.** 3 words of incrementing bytes 00..17 → 8 coefficients: 0x020100, 0x050403, …, 0x171615; `in_ready` low while `byte_cnt` ≥ 3.
4. **Backpressure.** `coeff_ready` held 0 for 10 cycles with accepted data pending → `coeff_out`/`coeff_idx` stable, no bytes dropped; release → sequence continues unbroken.
5. **Completion.** Stream of all-zero words → 256 coefficients of 0 with idx 0..255; `done` one-cycle pulse after idx 255 handshake; then `in_ready`=0 and `busy`=0.
6. **Restart and reset.** `start` asserted at idx 100 → next coefficient has idx 0 from fresh bytes; `rst_n` low mid-RUN → all outputs at reset values.
